fifo_eth_rd_ctrl: RTL and testbench
===================================

# fifo_eth_rd_ctrl

Read-side controller for the `fifo_eth` asynchronous FIFO (8-bit write, 32-bit read, 64-word read depth, almost_empty at 4 words, no output register). It runs in the FIFO read clock domain and sequences `rd_en` so that the FIFO contents leave as framed words on a valid/ready stream. A frame is closed on a fixed word count, or by an idle timeout when the FIFO underruns. It also tolerates downstream backpressure without losing words or over-reading the FIFO.

## Interface
- `DATA_WIDTH`, 32: FIFO read width and stream width.
- `FRAME_WORDS`, 64: words per full frame; legal range 2..65535.
- `TIMEOUT_CYC`, 256: idle cycles before a partial frame is started or closed; legal range 1..65535.
- `CNT_WIDTH`, 16: width of `frame_cnt`.

Ports:
- `clk`  in  1  FIFO read clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  when low, no new frame starts; a frame already in progress completes.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO data; valid in the cycle after `fifo_rd_en`.
- `fifo_rd_empty`  in  1  FIFO empty flag.
- `fifo_almost_empty`  in  1  high while the FIFO holds 4 words or fewer.
- `m_data`  out  DATA_WIDTH  stream data.
- `m_valid`  out  1  stream valid.
- `m_last`  out  1  marks the last word of a frame.
- `m_ready`  in  1  stream ready.
- `frame_cnt`  out  CNT_WIDTH  count of completed frames; wraps.
- `short_frame`  out  1  one-cycle pulse when a timeout-closed frame completes.
- `busy`  out  1  high when the state is not IDLE.

## Operation
**Reset.** While `rst_n` = 0, the block is held in its reset state:
- state = IDLE;
- all outputs = 0;
- queue, in-flight flag, and all counters cleared.

**Datapath.** One FIFO read can be in flight. Read data lands in a 2-entry queue Q. The head of Q moves to the output register (`m_data`, `m_valid`, `m_last`).

**Read-issue rule.** `fifo_rd_en` = 1 only when all of the following hold:
- state = STREAM;
- `!fifo_rd_empty`;
- reads issued in this frame < `FRAME_WORDS`;
- in-flight (0/1) + Q occupancy < 2.

**Head-move rule.** The head of Q moves to the output register when the output register is free (`!m_valid` or `m_ready`) and at least one of these holds:
- Q holds 2 words;
- a read is in flight;
- the head is word index `FRAME_WORDS`-1;
- the timeout has fired.

When a word moves, `m_last` = (index = `FRAME_WORDS`-1) or timeout fired.

**State machine.**
- IDLE → STREAM when `enable` && `!fifo_rd_empty` && (`!fifo_almost_empty` or the idle-wait counter ≥ `TIMEOUT_CYC`).
  - The idle-wait counter increments each IDLE cycle in which `!fifo_rd_empty` holds, and clears otherwise.
- STREAM → LAST when the `FRAME_WORDS`-th read is issued, or when the timeout fires.
  - The timeout counter increments in STREAM while Q = 1, nothing is in flight, and `fifo_rd_empty` = 1.
  - It clears on any read.
  - It fires when it reaches `TIMEOUT_CYC`.
- LAST: no reads are issued; the block drains Q.
- LAST → IDLE on `m_valid && m_ready && m_last`.
  - `frame_cnt` increments by 1 on this transition.
  - `short_frame` pulses if the frame was closed by the timeout.

**Boundaries.**
- With `m_ready` held low, at most 3 words are outstanding (1 in the output register, 2 in Q), so there is no FIFO over-read.
- `enable` falling mid-frame has no effect on the current frame.
- An asynchronous reset mid-frame discards the words in Q and in the output register.
- A frame never contains 0 words.

## Timing
- Read latency: `fifo_rd_en` at cycle t; data is captured into Q at the end of t+1.
- First `m_valid` appears no earlier than t+2.
- Sustained throughput is 1 word/cycle while `m_ready` = 1 and the FIFO is non-empty.
- `m_data` and `m_last` are stable while `m_valid && !m_ready`.
- `short_frame` is asserted in the cycle after the last handshake.
- `frame_cnt` updates in that same cycle.

## Structure
- `fifo_eth_pkg` holds:
  - the state enum (IDLE, STREAM, LAST);
  - the `FRAME_WORDS`/`TIMEOUT_CYC` defaults;
  - the clog2-derived word-index width (clog2 of `FRAME_WORDS`+1).
- Sub-module `fifo_eth_rd_q` is the 2-entry queue:
  - inputs: push, pop, data;
  - outputs: count, head.
- Everything else lives in `fifo_eth_rd_ctrl`.

## Test plan
- **Full frame.** Preload 70 words (value = index) with `m_ready` = 1 → 64 words 0..63 are emitted, with `m_last` on word 63; `frame_cnt` = 1. A second frame starts at word 64 once the FIFO passes the almost_empty threshold (>4 words) or the idle wait expires.
- **Backpressure.** Hold `m_ready` low for 20 cycles mid-frame → `fifo_rd_en` stops after 3 outstanding words. Resuming produces a gap-free sequence with no duplicates.
- **Underrun timeout.** Write 10 words, then stop; `TIMEOUT_CYC` = 8 → 10 words are emitted, `m_last` is on word 9, and `short_frame` pulses once. `m_last` asserts 8 cycles after the FIFO goes empty.
- **Small start.** Write 3 words (almost_empty stays high) → `busy` goes high only after `TIMEOUT_CYC` idle cycles. Then 3 words are emitted with `m_last` on the third.
- **Disable.** Drop `enable` at word 30 → the frame completes at word 63, and the block stays in IDLE with 6 words remaining in the FIFO.
- **Reset mid-frame.** Assert `rst_n` = 0 at word 20 → all outputs are 0 immediately. After release the block is in IDLE, and `frame_cnt` = 0.

Source files
------------

// File: rtl/fifo_eth_pkg.sv
// Shared types and defaults for the fifo_eth read-side controller.
package fifo_eth_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        LAST   = 2'd2
    } rd_state_e;

    localparam int FRAME_WORDS_DEF = 64;
    localparam int TIMEOUT_CYC_DEF = 256;

    // Width needed to count 0..frame_words inclusive.
    function automatic int idx_width(input int frame_words);
        return $clog2(frame_words + 1);
    endfunction

    localparam int IDX_W_DEF = idx_width(FRAME_WORDS_DEF);

endpackage

// File: rtl/fifo_eth_rd_q.sv
// Two-entry holding queue between the FIFO read port and the stream output register.
module fifo_eth_rd_q
    import fifo_eth_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] ent0;
    logic [DATA_WIDTH-1:0] ent1;

    assign head = ent0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0 <= data;
                    else               ent1 <= data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // simultaneous push/pop keeps occupancy; new word lands behind the survivor
                    if (count == 2'd1) begin
                        ent0 <= data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_eth_rd_ctrl.sv
// Read-side sequencer for fifo_eth: drains the FIFO into framed valid/ready words.
//   state  | meaning
//   IDLE   | waiting for enough data (or idle wait expiry) to start a frame
//   STREAM | issuing FIFO reads for the current frame
//   LAST   | reads finished, draining queue until the m_last handshake
module fifo_eth_rd_ctrl
    import fifo_eth_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    input  logic                  fifo_almost_empty,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic                  short_frame,
    output logic                  busy
);

    localparam int IDX_W = idx_width(FRAME_WORDS);
    localparam logic [IDX_W-1:0] FRAME_LEN = IDX_W'(FRAME_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_WORDS - 1);
    localparam logic [15:0]      TO_LIM    = 16'(TIMEOUT_CYC);

    rd_state_e             state;
    rd_state_e             state_nxt;
    logic                  in_flight;
    logic [IDX_W-1:0]      rd_cnt;
    logic [IDX_W-1:0]      out_idx;
    logic [15:0]           to_cnt;
    logic [15:0]           idle_cnt;
    logic                  to_flag;
    logic [1:0]            q_count;
    logic [DATA_WIDTH-1:0] q_head;
    logic [1:0]            occ;
    logic                  out_free;
    logic                  to_hit;
    logic                  fired;
    logic                  move;
    logic                  rd_issue;
    logic                  start;
    logic                  frame_done;

    fifo_eth_rd_q #(.DATA_WIDTH(DATA_WIDTH)) u_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_flight),
        .pop   (move),
        .data  (fifo_rd_data),
        .count (q_count),
        .head  (q_head)
    );

    always_comb begin
        out_free   = !m_valid || m_ready;
        to_hit     = (state == STREAM) && (to_cnt >= TO_LIM);
        fired      = to_flag || to_hit;
        move       = out_free && (q_count != 2'd0) &&
                     ((q_count == 2'd2) || in_flight || (out_idx == LAST_IDX) || fired);
        // occupancy after this cycle's pop, so a read can overlap a head move
        occ        = 2'(in_flight) + q_count - 2'(move);
        rd_issue   = (state == STREAM) && !fifo_rd_empty && !to_hit &&
                     (rd_cnt < FRAME_LEN) && (occ < 2'd2);
        start      = enable && !fifo_rd_empty && (!fifo_almost_empty || (idle_cnt >= TO_LIM));
        frame_done = m_valid && m_ready && m_last;
        fifo_rd_en = rd_issue;
        busy       = (state != IDLE);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = STREAM;
            STREAM:  if ((rd_issue && (rd_cnt == LAST_IDX)) || to_hit) state_nxt = LAST;
            LAST:    if (frame_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_flight   <= 1'b0;
            rd_cnt      <= '0;
            out_idx     <= '0;
            to_cnt      <= '0;
            idle_cnt    <= '0;
            to_flag     <= 1'b0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            frame_cnt   <= '0;
            short_frame <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_flight <= rd_issue;

            if ((state == IDLE) && !fifo_rd_empty) begin
                if (idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 16'd1;
            end else begin
                idle_cnt <= '0;
            end

            if ((state == IDLE) && start) begin
                rd_cnt  <= '0;
                out_idx <= '0;
                to_cnt  <= '0;
                to_flag <= 1'b0;
            end else begin
                if (rd_issue) rd_cnt <= rd_cnt + IDX_W'(1);
                if (move)     out_idx <= out_idx + IDX_W'(1);
                if (rd_issue) begin
                    to_cnt <= '0;
                end else if ((state == STREAM) && (q_count == 2'd1) && !in_flight &&
                             fifo_rd_empty && (to_cnt < TO_LIM)) begin
                    to_cnt <= to_cnt + 16'd1;
                end
                if (to_hit) to_flag <= 1'b1;
            end

            if (move) begin
                m_valid <= 1'b1;
                m_data  <= q_head;
                m_last  <= (out_idx == LAST_IDX) || fired;
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end

            short_frame <= (state == LAST) && frame_done && to_flag;
            if ((state == LAST) && frame_done) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_eth_rd_ctrl.sv
// Scoreboard bench for fifo_eth_rd_ctrl with a behavioural FIFO read port.
module tb_fifo_eth_rd_ctrl;

    localparam int DW = 32;
    localparam int FW = 64;
    localparam int TO = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          tb_rst;
    logic          enable;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_empty;
    logic          fifo_almost_empty;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;
    logic [CW-1:0] frame_cnt;
    logic          short_frame;
    logic          busy;

    always #5 clk = ~clk;

    fifo_eth_rd_ctrl #(
        .DATA_WIDTH  (DW),
        .FRAME_WORDS (FW),
        .TIMEOUT_CYC (TO),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (tb_rst),
        .enable            (enable),
        .fifo_rd_en        (fifo_rd_en),
        .fifo_rd_data      (fifo_rd_data),
        .fifo_rd_empty     (fifo_rd_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .m_data            (m_data),
        .m_valid           (m_valid),
        .m_last            (m_last),
        .m_ready           (m_ready),
        .frame_cnt         (frame_cnt),
        .short_frame       (short_frame),
        .busy              (busy)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    bit            last_set[int];
    int            cyc        = 0;
    int            rd_total   = 0;
    int            hs_total   = 0;
    int            sf_total   = 0;
    int            max_out    = 0;
    int            empty_cyc  = 0;
    int            last_cyc   = 0;
    int            exp_frames = 0;
    int            wr_idx     = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic upd_flags();
        fifo_rd_empty     = (fifo_q.size() == 0);
        fifo_almost_empty = (fifo_q.size() <= 4);
    endtask

    task automatic wr_words(input int n);
        repeat (n) begin
            fifo_q.push_back(32'(wr_idx));
            exp_q.push_back(32'(wr_idx));
            wr_idx++;
        end
        upd_flags();
    endtask

    // One clock: sample/score at negedge, then model the FIFO read after the rising edge.
    task automatic tick();
        logic          rd_s;
        logic          hs_s;
        logic [DW-1:0] w;
        @(negedge clk);
        rd_s = fifo_rd_en;
        hs_s = m_valid && m_ready;
        if (short_frame) sf_total++;
        if (hs_s) begin
            hs_total++;
            check_eq("word_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check_eq("word_data", m_data, w);
                check_eq("word_last", 32'(m_last), 32'(last_set.exists(int'(w))));
            end
            if (m_last) last_cyc = cyc;
        end
        if (rd_s) check_eq("no_overread", 32'(fifo_q.size() > 0), 32'd1);
        @(posedge clk);
        #1;
        cyc++;
        if (rd_s) begin
            rd_total++;
            if (fifo_q.size() > 0) begin
                fifo_rd_data = fifo_q.pop_front();
                if (fifo_q.size() == 0) empty_cyc = cyc;
            end
        end
        upd_flags();
        if (rd_total - hs_total > max_out) max_out = rd_total - hs_total;
    endtask

    task automatic wait_frames(input string tag, input int budget);
        int n = 0;
        while (frame_cnt != CW'(exp_frames) && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(frame_cnt), 32'(exp_frames));
        tick();
    endtask

    task automatic wait_hs(input string tag, input int target, input int budget);
        int n = 0;
        while (hs_total < target && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(hs_total >= target), 32'd1);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_m_valid"},     32'(m_valid),     32'd0);
        check_eq({pfx, "_m_data"},      m_data,           32'd0);
        check_eq({pfx, "_m_last"},      32'(m_last),      32'd0);
        check_eq({pfx, "_fifo_rd_en"},  32'(fifo_rd_en),  32'd0);
        check_eq({pfx, "_busy"},        32'(busy),        32'd0);
        check_eq({pfx, "_frame_cnt"},   32'(frame_cnt),   32'd0);
        check_eq({pfx, "_short_frame"}, 32'(short_frame), 32'd0);
    endtask

    initial begin
        int n;
        int gap;
        tb_rst       = 1'b0;
        enable       = 1'b0;
        m_ready      = 1'b0;
        fifo_rd_data = '0;
        upd_flags();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        tb_rst = 1'b1;

        // full frame of 64, then the 6 leftover words close on timeout
        enable  = 1'b1;
        m_ready = 1'b1;
        last_set[63] = 1'b1;
        last_set[69] = 1'b1;
        wr_words(70);
        exp_frames++;
        wait_frames("full_frame_cnt", 300);
        check_eq("full_frame_words", 32'(hs_total), 32'd64);
        exp_frames++;
        wait_frames("second_frame_cnt", 300);
        check_eq("second_frame_words", 32'(hs_total), 32'd70);
        check_eq("second_frame_short", 32'(sf_total), 32'd1);

        // backpressure mid-frame
        last_set[109] = 1'b1;
        wr_words(40);
        wait_hs("bp_reach", 80, 200);
        m_ready = 1'b0;
        repeat (20) tick();
        check_eq("bp_outstanding", 32'(rd_total - hs_total), 32'd3);
        check_eq("bp_max_out", 32'(max_out), 32'd3);
        check_eq("bp_rd_en_stopped", 32'(fifo_rd_en), 32'd0);
        check_eq("bp_valid_held", 32'(m_valid), 32'd1);
        check_eq("bp_data_held", m_data, exp_q[0]);
        m_ready = 1'b1;
        exp_frames++;
        wait_frames("bp_frame_cnt", 300);
        check_eq("bp_words", 32'(hs_total), 32'd110);
        check_eq("bp_short", 32'(sf_total), 32'd2);

        // underrun closes a 10-word frame by timeout
        last_set[119] = 1'b1;
        wr_words(10);
        exp_frames++;
        wait_frames("underrun_frame_cnt", 200);
        check_eq("underrun_words", 32'(hs_total), 32'd120);
        check_eq("underrun_short", 32'(sf_total), 32'd3);
        gap = last_cyc - empty_cyc;
        check_eq("underrun_gap_in_window", 32'(gap >= TO && gap <= TO + 4), 32'd1);

        // below almost_empty: start only after the idle wait
        last_set[122] = 1'b1;
        wr_words(3);
        n = 0;
        while (!busy && n < 50) begin
            tick();
            n++;
        end
        check_eq("small_start_busy", 32'(busy), 32'd1);
        check_eq("small_start_delay_in_window", 32'(n >= TO && n <= TO + 4), 32'd1);
        exp_frames++;
        wait_frames("small_frame_cnt", 200);
        check_eq("small_words", 32'(hs_total), 32'd123);
        check_eq("small_short", 32'(sf_total), 32'd4);

        // enable dropped at word 30: frame still runs to 64 words
        last_set[186] = 1'b1;
        last_set[192] = 1'b1;
        wr_words(70);
        wait_hs("dis_reach", 153, 300);
        enable = 1'b0;
        exp_frames++;
        wait_frames("dis_frame_cnt", 300);
        check_eq("dis_words", 32'(hs_total), 32'd187);
        repeat (30) tick();
        check_eq("dis_idle", 32'(busy), 32'd0);
        check_eq("dis_fifo_left", 32'(fifo_q.size()), 32'd6);
        enable = 1'b1;
        exp_frames++;
        wait_frames("dis_drain_cnt", 200);
        check_eq("dis_drain_words", 32'(hs_total), 32'd193);
        check_eq("dis_drain_short", 32'(sf_total), 32'd5);

        // asynchronous reset mid-frame
        wr_words(40);
        wait_hs("rst_reach", 213, 200);
        check_eq("rst_pre_busy", 32'(busy), 32'd1);
        tb_rst = 1'b0;
        #1;
        check_outputs_zero("midrst");
        fifo_q.delete();
        exp_q.delete();
        fifo_rd_data = '0;
        upd_flags();
        repeat (3) tick();
        tb_rst = 1'b1;
        repeat (5) tick();
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        check_eq("post_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_eq("post_rst_valid", 32'(m_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
